// File: rtl/sid_mix_seq_if.sv
// Register write bus and sample output bus of the SID mixer.
// master = register host / sample consumer, slave = mixer.
interface sid_mix_seq_if #(
  parameter int OUT_W = 16
);
  logic                    WR;
  logic [4:0]              ADDR;
  logic [7:0]              DATA;
  logic signed [OUT_W-1:0] PRE_FILTER;
  logic signed [OUT_W-1:0] OUTPUT;
  logic                    OUT_VALID;
  logic                    OVERRUN;

  modport master (
    output WR, ADDR, DATA,
    input  PRE_FILTER, OUTPUT, OUT_VALID, OVERRUN
  );

  modport slave (
    input  WR, ADDR, DATA,
    output PRE_FILTER, OUTPUT, OUT_VALID, OVERRUN
  );
endinterface

// File: rtl/sid_mix_seq.sv
// Time-multiplexed SID output mixer: one multiplier stepped over the voices per CLKen frame.
// CLKen to OUT_VALID is NUM_VOICES+4 cycles; CLKen outside IDLE is dropped and flagged in OVERRUN.
module sid_mix_seq #(
  parameter int NUM_VOICES = 3,
  parameter int VOICE_W    = 12,
  parameter int ENV_W      = 8,
  parameter int OUT_W      = 16,
  parameter int HEADROOM   = 3
) (
  input  logic                             CLK,
  input  logic                             RSTn,
  input  logic                             CLKen,
  input  logic [NUM_VOICES*VOICE_W-1:0]    VOICE_IN,
  input  logic [NUM_VOICES*ENV_W-1:0]      ENV_IN,
  input  logic signed [OUT_W-1:0]          FILT_LP,
  input  logic signed [OUT_W-1:0]          FILT_BP,
  input  logic signed [OUT_W-1:0]          FILT_HP,
  sid_mix_seq_if.slave                     bus
);

  localparam int ACC_W  = OUT_W + 3;
  localparam int PROD_W = VOICE_W + ENV_W + 1;
  localparam int PW     = (PROD_W > ACC_W) ? PROD_W : ACC_W;
  localparam int SHR    = VOICE_W + ENV_W - OUT_W + HEADROOM;

  typedef enum logic [2:0] {IDLE, MUL, SUM, CLIP, VOL} state_t;
  state_t state, state_nxt;

  logic [3:0] route_r, route_s;
  logic [2:0] mode_r, mode_s;
  logic [3:0] vol_r, vol_s;
  logic       off3_r, off3_s;

  logic [NUM_VOICES*VOICE_W-1:0] voice_q;
  logic [NUM_VOICES*ENV_W-1:0]   env_q;
  logic [2:0]                    idx;
  logic [1:0]                    pipe_idx;
  logic                          pipe_vld;
  logic signed [ACC_W-1:0]       pipe_amp;
  logic signed [ACC_W-1:0]       filt_acc, byp_acc, post_q;
  logic signed [OUT_W-1:0]       clip_q, pre_q, out_q;
  logic                          out_vld, overrun;

  // Pad the voice array to four entries so the index width stays fixed.
  logic [VOICE_W-1:0] v_arr [4];
  logic [ENV_W-1:0]   e_arr [4];
  for (genvar g = 0; g < 4; g++) begin : g_unpack
    if (g < NUM_VOICES) begin : g_used
      assign v_arr[g] = voice_q[g*VOICE_W +: VOICE_W];
      assign e_arr[g] = env_q[g*ENV_W +: ENV_W];
    end else begin : g_pad
      assign v_arr[g] = '0;
      assign e_arr[g] = '0;
    end
  end

  logic [VOICE_W-1:0]      v_cur;
  logic signed [PW-1:0]    s_ext, e_ext, prod;
  logic signed [ACC_W-1:0] amp, post_c;
  logic                    skip_byp;
  logic signed [OUT_W+4:0] vol_prod;

  assign v_cur = v_arr[idx[1:0]];
  assign s_ext = {{(PW-VOICE_W){~v_cur[VOICE_W-1]}}, ~v_cur[VOICE_W-1], v_cur[VOICE_W-2:0]};
  assign e_ext = {{(PW-ENV_W){1'b0}}, e_arr[idx[1:0]]};
  assign prod  = s_ext * e_ext;
  assign amp   = ACC_W'(prod >>> SHR);

  assign skip_byp = off3_s && (pipe_idx == 2'd2) && !route_s[2];

  assign post_c = byp_acc
                + (mode_s[0] ? ACC_W'(FILT_LP) : ACC_W'(0))
                + (mode_s[1] ? ACC_W'(FILT_BP) : ACC_W'(0))
                + (mode_s[2] ? ACC_W'(FILT_HP) : ACC_W'(0));

  assign vol_prod = clip_q * $signed({1'b0, vol_s});

  function automatic logic signed [OUT_W-1:0] sat(input logic signed [ACC_W-1:0] x);
    if ((&x[ACC_W-1:OUT_W-1]) || !(|x[ACC_W-1:OUT_W-1]))
      sat = x[OUT_W-1:0];
    else if (x[ACC_W-1])
      sat = {1'b1, {(OUT_W-1){1'b0}}};
    else
      sat = {1'b0, {(OUT_W-1){1'b1}}};
  endfunction

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (CLKen) state_nxt = MUL;
      MUL:     if (idx == 3'(NUM_VOICES) && pipe_vld) state_nxt = SUM;
      SUM:     state_nxt = CLIP;
      CLIP:    state_nxt = VOL;
      VOL:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      route_r  <= '0;
      mode_r   <= '0;
      vol_r    <= 4'hF;
      off3_r   <= 1'b0;
      route_s  <= '0;
      mode_s   <= '0;
      vol_s    <= 4'hF;
      off3_s   <= 1'b0;
      voice_q  <= '0;
      env_q    <= '0;
      idx      <= '0;
      pipe_idx <= '0;
      pipe_vld <= 1'b0;
      pipe_amp <= '0;
      filt_acc <= '0;
      byp_acc  <= '0;
      post_q   <= '0;
      clip_q   <= '0;
      pre_q    <= '0;
      out_q    <= '0;
      out_vld  <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (bus.WR) begin
        case (bus.ADDR)
          5'h17: route_r <= 4'(bus.DATA[NUM_VOICES-1:0]);
          5'h18: begin
            off3_r <= bus.DATA[7];
            mode_r <= bus.DATA[6:4];
            vol_r  <= bus.DATA[3:0];
          end
          default: ;
        endcase
      end

      if (CLKen && state != IDLE) overrun <= 1'b1;
      out_vld <= (state == VOL);

      case (state)
        IDLE: if (CLKen) begin
          // Shadows take the pre-write values when WR coincides with CLKen.
          voice_q  <= VOICE_IN;
          env_q    <= ENV_IN;
          route_s  <= route_r;
          mode_s   <= mode_r;
          vol_s    <= vol_r;
          off3_s   <= off3_r;
          filt_acc <= '0;
          byp_acc  <= '0;
          idx      <= '0;
          pipe_vld <= 1'b0;
        end
        MUL: begin
          if (idx != 3'(NUM_VOICES)) begin
            pipe_amp <= amp;
            pipe_idx <= idx[1:0];
            pipe_vld <= 1'b1;
            idx      <= idx + 3'd1;
          end else begin
            pipe_vld <= 1'b0;
          end
          if (pipe_vld) begin
            if (route_s[pipe_idx]) filt_acc <= filt_acc + pipe_amp;
            else if (!skip_byp)    byp_acc  <= byp_acc + pipe_amp;
          end
        end
        SUM: begin
          pre_q  <= sat(filt_acc);
          post_q <= post_c;
        end
        CLIP: clip_q <= sat(post_q);
        VOL:  out_q  <= OUT_W'(vol_prod >>> 4);
        default: ;
      endcase
    end
  end

  assign bus.PRE_FILTER = pre_q;
  assign bus.OUTPUT     = out_q;
  assign bus.OUT_VALID  = out_vld;
  assign bus.OVERRUN    = overrun;

endmodule

// File: tb/tb_sid_mix_seq.sv
// Directed bench for sid_mix_seq (3 voices); expected samples are hand-computed constants.
module tb_sid_mix_seq;

  logic               clk = 1'b0;
  logic               RSTn;
  logic               CLKen;
  logic [35:0]        VOICE_IN;
  logic [23:0]        ENV_IN;
  logic signed [15:0] FILT_LP, FILT_BP, FILT_HP;

  int n_tests = 0;
  int n_fail  = 0;

  sid_mix_seq_if #(.OUT_W(16)) bus();

  sid_mix_seq #(
    .NUM_VOICES(3), .VOICE_W(12), .ENV_W(8), .OUT_W(16), .HEADROOM(3)
  ) dut (
    .CLK(clk), .RSTn(RSTn), .CLKen(CLKen),
    .VOICE_IN(VOICE_IN), .ENV_IN(ENV_IN),
    .FILT_LP(FILT_LP), .FILT_BP(FILT_BP), .FILT_HP(FILT_HP),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_v(input logic [11:0] v0, v1, v2, input logic [7:0] e0, e1, e2);
    VOICE_IN = {v2, v1, v0};
    ENV_IN   = {e2, e1, e0};
  endtask

  task automatic reg_wr(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.WR = 1'b1; bus.ADDR = a; bus.DATA = d;
    @(negedge clk);
    bus.WR = 1'b0;
  endtask

  // One frame; optional register write at frame cycle wr_at (0 = with CLKen), optional 2nd CLKen.
  task automatic frame(input string tag, input int wr_at, input logic [4:0] wa,
                       input logic [7:0] wd, input bit extra);
    int lat;
    @(negedge clk);
    CLKen = 1'b1; bus.WR = (wr_at == 0); bus.ADDR = wa; bus.DATA = wd;
    @(negedge clk);
    CLKen = 1'b0; bus.WR = 1'b0;
    lat = 0;
    while (!bus.OUT_VALID && lat < 20) begin
      @(negedge clk);
      lat++;
      bus.WR = (wr_at > 0 && lat == wr_at);
      CLKen  = (extra && lat == 2);
    end
    CLKen = 1'b0; bus.WR = 1'b0;
    chk({tag, "_lat"}, lat, 7);
    @(negedge clk);
    chk({tag, "_vld_pulse"}, int'(bus.OUT_VALID), 0);
  endtask

  task automatic count_vld(input int cycles, output int cnt);
    cnt = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (bus.OUT_VALID) cnt++;
    end
  endtask

  task automatic chk_out(input string tag, input int pre, input int out);
    chk({tag, "_pre"}, int'(bus.PRE_FILTER), pre);
    chk({tag, "_out"}, int'(bus.OUTPUT), out);
  endtask

  int cnt;

  initial begin
    RSTn = 1'b0; CLKen = 1'b0;
    bus.WR = 1'b0; bus.ADDR = '0; bus.DATA = '0;
    FILT_LP = '0; FILT_BP = '0; FILT_HP = '0;
    set_v(12'h000, 12'h000, 12'h000, 8'h00, 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    chk_out("rst", 0, 0);
    chk("rst_vld", int'(bus.OUT_VALID), 0);
    chk("rst_ovr", int'(bus.OVERRUN), 0);
    RSTn = 1'b1;

    // Single bypassed voice at full scale, both polarities, then volume.
    set_v(12'hFFF, 12'h000, 12'h000, 8'hFF, 8'h00, 8'h00);
    frame("pos", -1, 5'h0, 8'h0, 1'b0);
    chk_out("pos", 0, 3823);
    chk("pos_ovr", int'(bus.OVERRUN), 0);
    set_v(12'h000, 12'h000, 12'h000, 8'hFF, 8'h00, 8'h00);
    frame("neg", -1, 5'h0, 8'h0, 1'b0);
    chk_out("neg", 0, -3825);
    reg_wr(5'h18, 8'h00);
    frame("vol0", -1, 5'h0, 8'h0, 1'b0);
    chk_out("vol0", 0, 0);

    // Mid-scale voice with half envelope: amp 1024.
    reg_wr(5'h18, 8'h0F);
    set_v(12'hC00, 12'h000, 12'h000, 8'h80, 8'h00, 8'h00);
    frame("mid", -1, 5'h0, 8'h0, 1'b0);
    chk_out("mid", 0, 960);
    reg_wr(5'h18, 8'h08);
    frame("mid_v8", -1, 5'h0, 8'h0, 1'b0);
    chk_out("mid_v8", 0, 512);
    reg_wr(5'h18, 8'h0F);

    // Filter routing and register snapshot timing.
    set_v(12'hFFF, 12'h000, 12'h000, 8'hFF, 8'h00, 8'h00);
    reg_wr(5'h17, 8'h01);
    frame("rt1", -1, 5'h0, 8'h0, 1'b0);
    chk_out("rt1", 4078, 0);
    frame("rt_midwr", 2, 5'h17, 8'h00, 1'b0);
    chk_out("rt_midwr", 4078, 0);
    frame("rt_after", -1, 5'h0, 8'h0, 1'b0);
    chk_out("rt_after", 0, 3823);
    frame("rt_samewr", 0, 5'h17, 8'h01, 1'b0);
    chk_out("rt_samewr", 0, 3823);
    frame("rt_next", -1, 5'h0, 8'h0, 1'b0);
    chk_out("rt_next", 4078, 0);
    reg_wr(5'h17, 8'h00);

    // Filter mode selection and saturation at both rails.
    FILT_LP = 16'sh7FFF;
    reg_wr(5'h18, 8'h1F);
    frame("lp", -1, 5'h0, 8'h0, 1'b0);
    chk_out("lp", 0, 30719);
    FILT_BP = -16'sd1000;
    reg_wr(5'h18, 8'h2F);
    frame("bp", -1, 5'h0, 8'h0, 1'b0);
    chk_out("bp", 0, 2885);
    set_v(12'h000, 12'h000, 12'h000, 8'hFF, 8'h00, 8'h00);
    FILT_HP = -16'sd32768;
    reg_wr(5'h18, 8'h4F);
    frame("hp", -1, 5'h0, 8'h0, 1'b0);
    chk_out("hp", 0, -30720);
    FILT_LP = '0; FILT_BP = '0; FILT_HP = '0;

    // Voice 3 mute only applies to the bypass path.
    set_v(12'h000, 12'h000, 12'hFFF, 8'h00, 8'h00, 8'hFF);
    reg_wr(5'h18, 8'h8F);
    frame("off3", -1, 5'h0, 8'h0, 1'b0);
    chk_out("off3", 0, 0);
    reg_wr(5'h17, 8'h04);
    frame("off3_flt", -1, 5'h0, 8'h0, 1'b0);
    chk_out("off3_flt", 4078, 0);
    reg_wr(5'h17, 8'h00);
    reg_wr(5'h18, 8'h0F);
    frame("v2_on", -1, 5'h0, 8'h0, 1'b0);
    chk_out("v2_on", 0, 3823);

    // All three voices summed, then one of them filtered.
    set_v(12'hFFF, 12'hFFF, 12'hFFF, 8'hFF, 8'hFF, 8'hFF);
    frame("sum3", -1, 5'h0, 8'h0, 1'b0);
    chk_out("sum3", 0, 11469);
    reg_wr(5'h17, 8'h02);
    frame("sum3_rt", -1, 5'h0, 8'h0, 1'b0);
    chk_out("sum3_rt", 4078, 7646);
    reg_wr(5'h17, 8'h00);

    // Overrun: second CLKen mid-frame is dropped but flagged and held.
    set_v(12'hFFF, 12'h000, 12'h000, 8'hFF, 8'h00, 8'h00);
    frame("ovr", -1, 5'h0, 8'h0, 1'b1);
    chk_out("ovr", 0, 3823);
    count_vld(12, cnt);
    chk("ovr_extra_vld", cnt, 0);
    chk("ovr_flag", int'(bus.OVERRUN), 1);
    frame("ovr_hold", -1, 5'h0, 8'h0, 1'b0);
    chk("ovr_held", int'(bus.OVERRUN), 1);

    // Reset mid-frame aborts the frame and restores register defaults.
    set_v(12'hFFF, 12'hFFF, 12'h000, 8'hFF, 8'hFF, 8'h00);
    reg_wr(5'h17, 8'h01);
    reg_wr(5'h18, 8'h08);
    frame("pre_rst", -1, 5'h0, 8'h0, 1'b0);
    chk_out("pre_rst", 4078, 2039);
    @(negedge clk); CLKen = 1'b1;
    @(negedge clk); CLKen = 1'b0;
    repeat (3) @(negedge clk);
    RSTn = 1'b0;
    @(negedge clk);
    RSTn = 1'b1;
    count_vld(12, cnt);
    chk("rst_mid_vld", cnt, 0);
    chk_out("rst_mid", 0, 0);
    chk("rst_mid_ovr", int'(bus.OVERRUN), 0);
    frame("post_rst", -1, 5'h0, 8'h0, 1'b0);
    chk_out("post_rst", 0, 7646);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sid_mix_seq.md
Name: sid_mix_seq

Overview:
- Parametrised, time-multiplexed successor to the SID output stage. Scales N voices by their envelopes, routes each voice to the filter input or to the bypass path, then sums bypass and the selected LP/BP/HP filter outputs, saturates, and applies master volume.
- One shared multiplier is stepped through the voices in sequence, once per CLKen frame. Output carries a valid strobe and an overrun flag.
- Sits between the voice/envelope generators and the filter/DAC in the SID core.

Parameters:
- NUM_VOICES, 3, voice count, 1..4.
- VOICE_W, 12, unsigned offset-binary voice width.
- ENV_W, 8, unsigned envelope width.
- OUT_W, 16, signed width of the mixer, filter and output paths.
- HEADROOM, 3, arithmetic right shift applied to each scaled voice before summing.

Ports:
- CLK  in  1  master clock.
- RSTn  in  1  synchronous active-low reset.
- CLKen  in  1  1 MHz sample enable; starts a frame.
- WR  in  1  register write strobe.
- ADDR  in  5  register address.
- DATA  in  8  write data.
- VOICE_IN  in  NUM_VOICES*VOICE_W  packed voices, voice 0 in the LSBs.
- ENV_IN  in  NUM_VOICES*ENV_W  packed envelopes, voice 0 in the LSBs.
- FILT_LP / FILT_BP / FILT_HP  in  OUT_W each  signed filter outputs.
- PRE_FILTER  out  OUT_W  signed, saturated sum of filter-routed voices.
- OUTPUT  out  OUT_W  signed final sample.
- OUT_VALID  out  1  one-cycle pulse when OUTPUT updates.
- OVERRUN  out  1  sticky: a CLKen arrived while busy.

Behaviour:
- Reset (RSTn=0 at a CLK edge):
  - route=0, mode=0, volume=0xF, off3=0.
  - PRE_FILTER=0, OUTPUT=0, OUT_VALID=0, OVERRUN=0.
  - FSM goes to IDLE and the accumulators clear.
  - Reset during a frame aborts the frame with no OUT_VALID.
- Registers (written on WR, independent of CLKen):
  - 0x17: route <= DATA[NUM_VOICES-1:0].
  - 0x18: mode <= DATA[6:4], volume <= DATA[3:0], off3 <= DATA[7].
  - Other addresses are ignored.
- Register snapshot:
  - route, mode, volume and off3 are copied into shadow registers at frame start.
  - A write during a frame affects only the next frame.
- Voice conversion: s = {~v[MSB], v[MSB-1:0]} (signed).
- Scaling: amp = (s * env) >>> (VOICE_W+ENV_W-OUT_W), then >>> HEADROOM. Shifts are arithmetic (floor).
- Accumulators are OUT_W+3 bits wide; no intermediate wrap.
- FSM, with cycles counted from the CLK edge that samples CLKen=1:
  - IDLE: on CLKen, latch VOICE_IN, ENV_IN and the register shadows, clear both accumulators, index i=0, go to MUL.
  - MUL: each cycle multiply voice i into a pipeline register. On the next cycle add it to the filter accumulator if route[i]=1, otherwise to the bypass accumulator. The bypass add is skipped when off3=1, i==2 and route[2]=0. Leave MUL after i=NUM_VOICES-1 has been accumulated.
  - SUM:
    - PRE_FILTER <= sat(filter_acc).
    - post = bypass_acc + (mode[0]?FILT_LP:0) + (mode[1]?FILT_BP:0) + (mode[2]?FILT_HP:0).
    - Filter inputs are sampled in this cycle.
  - CLIP: post is saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - VOL: OUTPUT <= (clip * volume) >>> 4, and OUT_VALID=1 for exactly this cycle. Return to IDLE.
- Latency: CLKen to OUT_VALID is NUM_VOICES+4 cycles. The CLK:CLKen ratio must be at least NUM_VOICES+5.
- Overrun: CLKen=1 outside IDLE is ignored, the current frame completes unaltered, and OVERRUN sets to 1. OVERRUN clears only on reset.
- CLKen and WR in the same cycle: the snapshot takes the pre-write value.
- OUTPUT and PRE_FILTER hold their values between frames.

Test Plan:
- NUM_VOICES=3, voice0=0xFFF, env0=0xFF, other envelopes 0, route=0, mode=0, volume=0xF, one CLKen -> OUT_VALID 7 cycles later, OUTPUT=3823 (amp 4078), PRE_FILTER=0.
- Same stimulus with voice0=0x000 -> amp -4080, OUTPUT=-3825. Then write volume=0 -> next frame OUTPUT=0.
- route=0x1, voice0=0xFFF, env0=0xFF -> PRE_FILTER=4078, OUTPUT=0. Write 0x17 mid-frame -> current frame unchanged, next frame reflects the new route.
- Bypass voice0 at 4078, FILT_LP=0x7FFF, mode=LP, volume=0xF -> post saturates to 32767, OUTPUT=30719.
- voice2=0xFFF, env2=0xFF, route[2]=0, off3=1 -> OUTPUT=0. Set route[2]=1 -> PRE_FILTER=4078 even with off3=1.
- Two CLKen pulses 3 cycles apart -> a single OUT_VALID, OVERRUN=1 and held; RSTn=0 mid-frame -> no OUT_VALID, all outputs 0, volume=0xF.
